// File: rtl/im_arb_pkg.sv
// Shared constants and types for the instruction-memory fetch arbiter.
package im_arb_pkg;

    // Memory map of the core
    localparam logic [31:0] DATA_BASE_DEF  = 32'h0000_0000;
    localparam logic [31:0] TEXT_BASE_DEF  = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF   = 4096;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Which port (if any) receives a response in the current cycle
    typedef enum logic [2:0] {
        R_NONE     = 3'd0,
        R_IF       = 3'd1,
        R_DBG      = 3'd2,
        R_ZERO_IF  = 3'd3,
        R_ZERO_DBG = 3'd4
    } resp_state_e;

    function automatic logic word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/im_fetch_arbiter_if.sv
// Fetch, debug and instruction-memory signals of the arbiter.
// slave = arbiter view, master = core/loader/memory environment view.
interface im_fetch_arbiter_if #(
    parameter int unsigned IDX_W = 12
) ();
    logic             if_req;
    logic [31:0]      if_addr;
    logic             if_gnt;
    logic             if_rvalid;
    logic [31:0]      if_rdata;

    logic             dbg_req;
    logic             dbg_we;
    logic [31:0]      dbg_addr;
    logic [31:0]      dbg_wdata;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic [31:0]      dbg_rdata;
    logic             dbg_err;

    logic             mem_en;
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
               mem_en, mem_we, mem_widx, mem_wdata
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
               mem_en, mem_we, mem_widx, mem_wdata
    );
endinterface

// File: rtl/im_addr_check.sv
// Byte address -> IM word index, range and alignment decode (purely combinational).
module im_addr_check
    import im_arb_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_DEF,
    parameter int unsigned IM_WORDS  = IM_WORDS_DEF,
    parameter int unsigned IDX_W     = 12
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] index_o,
    output logic             in_range_o,
    output logic             aligned_o
);
    // 33-bit arithmetic so addresses below the base show up as a borrow, never a wrap
    localparam logic [32:0] SPAN = 33'(IM_WORDS) << 2;

    logic [32:0] offset_s;

    assign offset_s   = {1'b0, addr_i} - {1'b0, TEXT_BASE};
    assign in_range_o = ~offset_s[32] & (offset_s < SPAN);
    assign index_o    = offset_s[IDX_W+1:2];
    assign aligned_o  = word_aligned(addr_i);

endmodule

// File: rtl/im_fetch_arbiter.sv
// Arbitrates instruction fetch and loader/debug accesses onto one IM port.
// Fetch has priority; a starvation counter forces a debug grant.
module im_fetch_arbiter
    import im_arb_pkg::*;
#(
    parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEF,
    parameter int unsigned IM_WORDS   = IM_WORDS_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    im_fetch_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(IM_WORDS);

    logic [IDX_W-1:0] if_idx_s, dbg_idx_s, mem_widx_s;
    logic             if_in_s, if_al_s, dbg_in_s, dbg_al_s;
    logic             if_ok_s, dbg_ok_s;
    logic             force_dbg_s, if_gnt_s, dbg_gnt_s;
    logic             mem_en_s, mem_we_s;
    logic [31:0]      mem_wdata_s, if_rdata_s, dbg_rdata_s;

    resp_state_e      state_q, state_d;
    logic [3:0]       starve_q, starve_d;
    logic             dbg_wr_q, dbg_wr_d;
    logic             if_rvalid_q, dbg_rvalid_q, dbg_err_q;

    im_addr_check #(.TEXT_BASE(TEXT_BASE), .IM_WORDS(IM_WORDS), .IDX_W(IDX_W)) u_if_chk (
        .addr_i     (bus.if_addr),
        .index_o    (if_idx_s),
        .in_range_o (if_in_s),
        .aligned_o  (if_al_s)
    );

    im_addr_check #(.TEXT_BASE(TEXT_BASE), .IM_WORDS(IM_WORDS), .IDX_W(IDX_W)) u_dbg_chk (
        .addr_i     (bus.dbg_addr),
        .index_o    (dbg_idx_s),
        .in_range_o (dbg_in_s),
        .aligned_o  (dbg_al_s)
    );

    assign if_ok_s  = if_in_s & if_al_s;
    assign dbg_ok_s = dbg_in_s & dbg_al_s;

    // Grant selection, IM command and next response state for this cycle
    always_comb begin
        force_dbg_s = bus.dbg_req & (starve_q == 4'(STARVE_MAX));
        if_gnt_s    = rst_ni & bus.if_req & ~force_dbg_s;
        dbg_gnt_s   = rst_ni & bus.dbg_req & ~if_gnt_s;
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_widx_s  = '0;
        mem_wdata_s = 32'd0;
        state_d     = R_NONE;
        dbg_wr_d    = 1'b0;
        if (if_gnt_s) begin
            mem_en_s   = if_ok_s;
            mem_widx_s = if_idx_s;
            state_d    = if_ok_s ? R_IF : R_ZERO_IF;
        end else if (dbg_gnt_s) begin
            mem_en_s    = dbg_ok_s;
            mem_we_s    = dbg_ok_s & bus.dbg_we;
            mem_widx_s  = dbg_idx_s;
            mem_wdata_s = bus.dbg_wdata;
            state_d     = dbg_ok_s ? R_DBG : R_ZERO_DBG;
            dbg_wr_d    = bus.dbg_we;
        end else begin
            state_d = R_NONE;
        end
        // Forced grant at STARVE_MAX clears the count, so it never exceeds 15
        if (bus.dbg_req & ~dbg_gnt_s) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = 4'd0;
        end
    end

    // Response FSM with registered valid/error flags; reset drops any pending response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= R_NONE;
            starve_q     <= 4'd0;
            dbg_wr_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            dbg_wr_q     <= dbg_wr_d;
            if_rvalid_q  <= (state_d == R_IF) | (state_d == R_ZERO_IF);
            dbg_rvalid_q <= (state_d == R_DBG) | (state_d == R_ZERO_DBG);
            dbg_err_q    <= (state_d == R_ZERO_DBG);
        end
    end

    // Route IM read data to the port that owns this cycle's response
    always_comb begin
        if_rdata_s  = 32'd0;
        dbg_rdata_s = 32'd0;
        case (state_q)
            R_IF:    if_rdata_s  = bus.mem_rdata;
            R_DBG:   dbg_rdata_s = dbg_wr_q ? 32'd0 : bus.mem_rdata;
            default: begin
                if_rdata_s  = 32'd0;
                dbg_rdata_s = 32'd0;
            end
        endcase
    end

    assign bus.if_gnt     = if_gnt_s;
    assign bus.dbg_gnt    = dbg_gnt_s;
    assign bus.mem_en     = mem_en_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_widx   = mem_widx_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_rdata   = if_rdata_s;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.dbg_rdata  = dbg_rdata_s;
    assign bus.dbg_err    = dbg_err_q;

endmodule
